// File: rtl/serial_add_ctrl.sv
// Sequencer and carry bit-slice for an N-bit serial adder driving external A/B/SUM shift registers.
// Define SERIAL_SUB_EN to honour the sub input (A-B via inverted B and carry-in of 1).
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic sub,
    input  logic a_bit,
    input  logic b_bit,
    output logic load,
    output logic shiftR,
    output logic sum_bit,
    output logic busy,
    output logic done,
    output logic cout,
    output logic ovf
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic           r_carry;
    logic           r_load;
    logic           r_shift;
    logic           r_busy;
    logic           r_done;
    logic           r_cout;
    logic           r_ovf;

    logic           w_op_sub;
    logic           w_carry_init;
    logic           w_b_eff;
    logic           w_carry_next;

`ifdef SERIAL_SUB_EN
    // Operation type is frozen at LOAD so later changes on sub cannot corrupt a running op.
    logic r_op_sub;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_sub <= 1'b0;
        end else if (r_state == LOAD) begin
            r_op_sub <= sub;
        end
    end

    assign w_op_sub     = r_op_sub;
    assign w_carry_init = sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_op_sub     = 1'b0;
    assign w_carry_init = 1'b0;
`endif

    assign w_b_eff      = b_bit ^ w_op_sub;
    assign w_carry_next = (a_bit & w_b_eff) | (a_bit & r_carry) | (w_b_eff & r_carry);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_carry <= 1'b0;
            r_load  <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= SHIFT;
                    r_load  <= 1'b0;
                    r_shift <= 1'b1;
                    r_carry <= w_carry_init;
                    r_count <= '0;
                    r_cout  <= 1'b0;
                    r_ovf   <= 1'b0;
                end
                SHIFT: begin
                    r_carry <= w_carry_next;
                    r_count <= r_count + CW'(1);
                    // Old carry here is the carry into the MSB, so it yields signed overflow.
                    if (r_count == LAST) begin
                        r_cout  <= w_carry_next;
                        r_ovf   <= r_carry ^ w_carry_next;
                        r_state <= DONE;
                        r_shift <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_load  <= 1'b0;
                    r_shift <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign load    = r_load;
    assign shiftR  = r_shift;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cout    = r_cout;
    assign ovf     = r_ovf;
    assign sum_bit = r_shift & (a_bit ^ w_b_eff ^ r_carry);

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer and bit-slice for the N-bit serial adder.
- Drives the load/shift controls of the three right-shifting operand/result registers (A, B, SUM), each with MSB serial-in.
- Computes one sum bit per cycle from the A and B LSBs with an internal carry flip-flop; the sum bit feeds the SUM register's serial-in.
- Reports completion, carry-out and signed overflow through a start/done handshake.

Parameters:
- N, 8, operand width in bits; legal range 2..64.
- CW, $clog2(N+1), shift-counter width (derived; not to be overridden).

Ports:
- clock  input  1  rising-edge clock, shared with the shift registers.
- reset  input  1  synchronous active-high reset.
- start  input  1  request an addition; sampled only in IDLE.
- sub  input  1  subtract request (used only with SERIAL_SUB_EN; ignored otherwise).
- a_bit  input  1  LSB of the A register (Q[0]).
- b_bit  input  1  LSB of the B register (Q[0]).
- load  output  1  parallel-load strobe to the A and B registers.
- shiftR  output  1  shift strobe to the A, B and SUM registers.
- sum_bit  output  1  serial sum bit, wired to the SUM register's lin.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- cout  output  1  final carry-out, registered.
- ovf  output  1  signed overflow (carry into MSB XOR carry-out), registered.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous, active-high, on port `reset`; it has priority over everything, including mid-operation.
- Reset values: state=IDLE, count=0, carry=0, load=0, shiftR=0, done=0, busy=0, cout=0, ovf=0.
- FSM states: IDLE, LOAD, SHIFT, DONE. load, shiftR, busy and done are Moore decodes of the state register.
- IDLE:
  - load=0, shiftR=0.
  - start=1 moves to LOAD.
  - start=0 stays in IDLE.
- LOAD (1 cycle):
  - load=1; the A/B registers capture their parallel inputs on this edge.
  - carry <= 0 (1 if subtracting, see Optional Feature); count <= 0; next state SHIFT.
- SHIFT (exactly N cycles):
  - shiftR=1.
  - sum_bit = a_bit ^ b_eff ^ carry, combinational, valid only while shiftR=1; forced to 0 in other states.
  - b_eff = b_bit, or ~b_bit when subtracting.
  - carry <= majority(a_bit, b_eff, carry).
  - count <= count+1.
  - On the cycle with count==N-1: cout <= new carry, ovf <= carry ^ new carry (old carry is the carry into the MSB), next state DONE.
- DONE (1 cycle): done=1, busy=1, shiftR=0, load=0; next state IDLE.
- Latency: start sampled high at edge t gives LOAD in cycle t+1, SHIFT in t+2..t+N+1, done=1 in t+N+2. The SUM register holds the full result from cycle t+N+2 on.
- Start while busy (LOAD/SHIFT/DONE): ignored, no queuing. start held high through DONE launches a new operation from the following IDLE cycle.
- cout/ovf: hold their values from DONE until the next LOAD; cleared to 0 in LOAD.
- Reset mid-SHIFT: returns to IDLE next edge, carry cleared, no done pulse. Partial register contents are not restored.
- Back-to-back operations: minimum start-to-start spacing is N+3 cycles.
- Width rules: the result is modulo 2^N; the carry beyond N bits is reported only on cout.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- Defined:
  - sub is registered in LOAD as op_sub.
  - If op_sub=1: carry initialised to 1 in LOAD, b_eff=~b_bit, result = A-B mod 2^N.
  - cout=1 means no borrow (A>=B unsigned); ovf is the signed overflow of the subtraction.
  - sub changes after LOAD have no effect.
- Undefined: sub port still present but ignored; op_sub logic absent; always addition.

Test Plan (N=8, bench instantiates the shift registers):
- Reset, then A=0x35, B=0x4A, pulse start -> load 1 cycle, shiftR 8 cycles, done at t+10; SUM=0x7F, cout=0, ovf=0.
- A=0xFF, B=0x01 -> SUM=0x00, cout=1, ovf=0. A=0x80, B=0x80 -> SUM=0x00, cout=1, ovf=1.
- A=0x7F, B=0x01 -> SUM=0x80, cout=0, ovf=1; cout/ovf stay stable for 5 idle cycles, then clear in the next LOAD.
- Pulse start again during SHIFT cycle 3 -> ignored: exactly 8 shiftR cycles and a single done. Assert reset in SHIFT cycle 5 -> IDLE next cycle, busy=0, no done, cout=0; a fresh start then completes normally.
- SERIAL_SUB_EN: A=0x10, B=0x01, sub=1 -> SUM=0x0F, cout=1, ovf=0. A=0x01, B=0x02, sub=1 -> SUM=0xFF, cout=0. Without the macro, the same stimulus yields SUM=0x11 and 0x03.
